// File: rtl/sop_mac_sequencer.sv
// Sequential multiply-accumulate engine: takes NUM_TERMS (a, b) pairs over a
// valid/ready handshake and presents their sum of products with a one-cycle strobe.
module sop_mac_sequencer #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_TERMS  = 4,
    parameter int ACC_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  sum_out,
    output logic                  sum_valid,
    output logic                  busy,
    output logic [4:0]            term_count
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic [ACC_WIDTH-1:0]    sum_q, sum_d;
    logic [4:0]              term_count_q, term_count_d;
    logic [2*DATA_WIDTH-1:0] product;
    logic [ACC_WIDTH-1:0]    acc_next;
    logic                    last_term;

    always_comb begin
        product   = a * b;
        // Full-width product is resized to the accumulator; the sum wraps modulo 2^ACC_WIDTH.
        acc_next  = acc_q + ACC_WIDTH'(product);
        last_term = (term_count_q == 5'(NUM_TERMS - 1));

        state_d      = state_q;
        acc_d        = acc_q;
        sum_d        = sum_q;
        term_count_d = term_count_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d        = '0;
                    term_count_d = '0;
                    state_d      = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d        = acc_next;
                    term_count_d = term_count_q + 5'd1;
                    if (last_term) begin
                        sum_d   = acc_next;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            sum_q        <= '0;
            term_count_q <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            sum_q        <= sum_d;
            term_count_q <= term_count_d;
        end
    end

    // Handshake and status decode straight from the state so reset clears them at once.
    assign in_ready   = (state_q == ACCUM);
    assign busy       = (state_q == ACCUM) || (state_q == DONE);
    assign sum_valid  = (state_q == DONE);
    assign sum_out    = sum_q;
    assign term_count = term_count_q;

endmodule

// File: tb/tb_sop_mac_sequencer.sv
// Self-checking bench for sop_mac_sequencer: directed and randomized sums checked
// against an arithmetic reference, with a narrow-accumulator instance for wrap.
module tb_sop_mac_sequencer;

    localparam int DW = 4;
    localparam int NT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;

    logic          in_ready, sum_valid, busy;
    logic [9:0]    sum_out;
    logic [4:0]    term_count;

    logic          in_ready8, sum_valid8, busy8;
    logic [7:0]    sum_out8;
    logic [4:0]    term_count8;

    int compared   = 0;
    int mismatched = 0;

    logic [DW-1:0] pa[NT];
    logic [DW-1:0] pb[NT];
    int            model_sum10 = 0;
    int            model_sum8  = 0;

    sop_mac_sequencer #(.DATA_WIDTH(DW), .NUM_TERMS(NT), .ACC_WIDTH(10)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sum_out(sum_out), .sum_valid(sum_valid), .busy(busy),
        .term_count(term_count)
    );

    sop_mac_sequencer #(.DATA_WIDTH(DW), .NUM_TERMS(NT), .ACC_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready8),
        .a(a), .b(b), .sum_out(sum_out8), .sum_valid(sum_valid8), .busy(busy8),
        .term_count(term_count8)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain sum of products reduced modulo each accumulator width.
    task automatic run_sum(input int gap_max, input bit hold_start);
        int total;
        int g;
        total = 0;
        for (int i = 0; i < NT; i++) total += int'(pa[i]) * int'(pb[i]);

        start = 1'b1;
        in_valid = 1'b0;
        step();
        if (!hold_start) start = 1'b0;
        check("accum_busy", 32'(busy), 32'd1);
        check("accum_ready", 32'(in_ready), 32'd1);
        check("accum_tc0", 32'(term_count), 32'd0);

        for (int i = 0; i < NT; i++) begin
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0;
                a = DW'($urandom);
                b = DW'($urandom);
                step();
                check("gap_tc", 32'(term_count), 32'(i));
                check("gap_sum_held", 32'(sum_out), 32'(model_sum10));
                check("gap_no_valid", 32'(sum_valid), 32'd0);
            end
            in_valid = 1'b1;
            a = pa[i];
            b = pb[i];
            step();
            if (i < NT - 1) begin
                check("xfer_tc", 32'(term_count), 32'(i + 1));
                check("xfer_no_valid", 32'(sum_valid), 32'd0);
                check("xfer_ready", 32'(in_ready), 32'd1);
            end
        end

        model_sum10 = total % 1024;
        model_sum8  = total % 256;
        in_valid = 1'b0;
        check("done_valid", 32'(sum_valid), 32'd1);
        check("done_sum", 32'(sum_out), 32'(model_sum10));
        check("done_valid8", 32'(sum_valid8), 32'd1);
        check("done_sum8_wrap", 32'(sum_out8), 32'(model_sum8));
        check("done_tc", 32'(term_count), 32'(NT));
        check("done_ready", 32'(in_ready), 32'd0);
        check("done_busy", 32'(busy), 32'd1);

        step();
        start = 1'b0;
        check("post_valid", 32'(sum_valid), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("post_ready", 32'(in_ready), 32'd0);
        check("post_tc_held", 32'(term_count), 32'(NT));
        check("post_sum_held", 32'(sum_out), 32'(model_sum10));
        step();
        check("no_restart", 32'(busy), 32'd0);
        check("no_restart8", 32'(busy8), 32'd0);
    endtask

    initial begin
        step();
        step();
        check("rst_sum", 32'(sum_out), 32'd0);
        check("rst_sum8", 32'(sum_out8), 32'd0);
        check("rst_tc", 32'(term_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_valid", 32'(sum_valid), 32'd0);
        rst = 1'b0;
        step();

        // Basic back-to-back run: (1,2),(3,4),(5,6),(7,8) -> 100
        for (int i = 0; i < NT; i++) begin
            pa[i] = DW'(2 * i + 1);
            pb[i] = DW'(2 * i + 2);
        end
        run_sum(0, 1'b0);

        // Max operands: 900, and 132 in the 8-bit instance
        for (int i = 0; i < NT; i++) begin
            pa[i] = 4'd15;
            pb[i] = 4'd15;
        end
        run_sum(0, 1'b0);

        // Backpressure with gaps up to 3 cycles
        for (int i = 0; i < NT; i++) begin
            pa[i] = DW'(2 * i + 1);
            pb[i] = DW'(2 * i + 2);
        end
        run_sum(3, 1'b0);

        // start held high through ACCUM and DONE must not restart
        run_sum(2, 1'b1);
        for (int i = 0; i < NT; i++) begin
            pa[i] = 4'd2;
            pb[i] = 4'd2;
        end
        run_sum(0, 1'b0);

        // in_valid in IDLE without start is not accepted
        in_valid = 1'b1;
        a = 4'd15;
        b = 4'd15;
        for (int k = 0; k < 3; k++) begin
            step();
            check("idle_ready", 32'(in_ready), 32'd0);
            check("idle_tc_held", 32'(term_count), 32'(NT));
            check("idle_sum_held", 32'(sum_out), 32'(model_sum10));
            check("idle_busy", 32'(busy), 32'd0);
        end
        in_valid = 1'b0;

        // Reset after two transfers discards the partial sum
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            a = 4'd9;
            b = 4'd7;
            step();
        end
        check("mid_tc2", 32'(term_count), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_sum10 = 0;
        model_sum8  = 0;
        check("mid_rst_sum", 32'(sum_out), 32'd0);
        check("mid_rst_tc", 32'(term_count), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_valid", 32'(sum_valid), 32'd0);
        step();
        check("mid_rst_no_strobe", 32'(sum_valid), 32'd0);
        in_valid = 1'b0;
        for (int i = 0; i < NT; i++) begin
            pa[i] = DW'(i + 3);
            pb[i] = DW'(12 - i);
        end
        run_sum(1, 1'b0);

        // Randomized runs
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < NT; i++) begin
                pa[i] = DW'($urandom);
                pb[i] = DW'($urandom);
            end
            run_sum(int'($urandom_range(3, 0)), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
